// File: rtl/floor_distance_rom.sv
// Per-row Q8.8 floor/ceiling distance table for the raycaster column.
// The table is built at elaboration and read with one cycle of latency.
module floor_distance_rom #(
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] floordist
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    if ((HEIGHT % 2) != 0 || DEPTH < HEIGHT) begin : g_bad_param
        $error("floor_distance_rom: HEIGHT must be even and fit in ADDR_W bits");
    end

    // round(HEIGHT*256 / k) for floor rows, mirrored for ceiling rows, zero beyond the screen
    function automatic logic [DATA_W-1:0] row_dist(input int unsigned y);
        longint unsigned yf;
        longint unsigned k;
        longint unsigned v;
        longint unsigned lim;
        if (y >= HEIGHT) begin
            return '0;
        end
        yf  = (y < HEIGHT / 2) ? 64'(HEIGHT - 1 - y) : 64'(y);
        k   = 64'd2 * yf - 64'(HEIGHT - 1);
        v   = (64'(HEIGHT) * 64'd512 + k) / (64'd2 * k);
        lim = (64'd1 << DATA_W) - 64'd1;
        if (v > lim) begin
            v = lim;
        end
        return DATA_W'(v);
    endfunction

    logic [DATA_W-1:0] rom_c [DEPTH];
    logic [DATA_W-1:0] floordist_d;
    logic [DATA_W-1:0] floordist_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom_c[g] = row_dist(32'(g));
    end

    always_comb begin
        floordist_d = rom_c[addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            floordist_q <= '0;
        end else begin
            floordist_q <= floordist_d;
        end
    end

    assign floordist = floordist_q;

endmodule

// File: tb/tb_floor_distance_rom.sv
// Scoreboard bench for floor_distance_rom: directed corners, full sweep, random addresses.
module tb_floor_distance_rom;

    localparam int unsigned H      = 240;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;

    typedef struct {
        int addr;
        int exp;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] floordist;
    logic              drive_v;

    exp_t exp_q[$];
    int   obs[H];
    int   n_checks;
    int   n_fail;

    floor_distance_rom #(
        .HEIGHT(H),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .floordist(floordist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: distance = H*256 / (2y - (H-1)), nearest-rounded, ceiling rows mirrored
    function automatic int model(input int y);
        int  yy;
        int  k;
        int  r;
        real v;
        if (y >= int'(H)) return 0;
        yy = (y < int'(H) / 2) ? int'(H) - 1 - y : y;
        k  = 2 * yy - (int'(H) - 1);
        v  = real'(H) * 256.0 / real'(k);
        r  = int'($floor(v + 0.5));
        if (r > 65535) r = 65535;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic apply(input int a, input int exp);
        exp_t e;
        @(negedge clk);
        addr    = ADDR_W'(a);
        drive_v = 1'b1;
        e.addr  = a;
        e.exp   = exp;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_v = 1'b0;
            addr    = ADDR_W'($urandom_range(0, 511));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        drive_v = 1'b0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        #2;
        check("scoreboard_drain", exp_q.size(), 0);
    endtask

    // Monitor: every edge that sampled a driven address owes one result on the next cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (drive_v && rst) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: got 0x%04h, expected no output", floordist);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("row%0d", e.addr), int'(floordist), e.exp);
                    if (e.addr >= 0 && e.addr < int'(H)) obs[e.addr] = int'(floordist);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        drive_v  = 1'b0;
        addr     = ADDR_W'(120);
        for (int i = 0; i < H; i++) obs[i] = -1;

        // Output pinned to zero while reset is held, even with clock running
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", int'(floordist), 0);
        end

        @(negedge clk);
        rst = 1'b1;
        apply(120, 'hF000);
        @(negedge clk);
        drive_v = 1'b0;
        @(posedge clk);
        #2;
        check("pre_async_reset", int'(floordist), 'hF000);
        rst = 1'b0;
        #1;
        check("async_reset", int'(floordist), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Directed corners, back to back
        apply(120, 'hF000);
        apply(121, 'h5000);
        apply(239, 'h0101);
        apply(130, 'h0B6E);
        apply(200, 'h017E);
        apply(119, 'hF000);
        apply(0,   'h0101);
        apply(109, 'h0B6E);
        apply(240, 0);
        apply(300, 0);
        apply(511, 0);
        apply(239, 'h0101);
        drain();

        // Full on-screen sweep with no bubbles
        for (int y = 0; y < int'(H); y++) apply(y, model(y));
        drain();

        for (int y = 0; y < int'(H) / 2; y++)
            check($sformatf("mirror%0d", y), obs[y], obs[int'(H) - 1 - y]);
        for (int y = int'(H) / 2; y < int'(H) - 1; y++)
            if (obs[y] < obs[y + 1]) check($sformatf("floor_mono%0d", y), obs[y + 1], obs[y]);
            else check($sformatf("floor_mono%0d", y), 1, 1 - int'(obs[y] < obs[y + 1]));
        for (int y = 0; y < int'(H) / 2 - 1; y++)
            check($sformatf("ceil_mono%0d", y), int'(obs[y] <= obs[y + 1]), 1);

        // Random addresses across the full address space with occasional idle gaps
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) idle(1);
            a = int'($urandom_range(0, 511));
            apply(a, model(a));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
